ext_pipe: RTL



---
 rtl/ext_pipe.sv | 119 +++++++++++
 1 files changed

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - pipelined immediate extender with valid/ready and 2-entry skid buffer
module ext_pipe #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam logic [2:0] OP_ZERO        = 3'd0;
    localparam logic [2:0] OP_SIGNED      = 3'd1;
    localparam logic [2:0] OP_HIGHPOS     = 3'd2;
    localparam logic [2:0] OP_SIGNED_SHL2 = 3'd3;
    localparam logic [2:0] OP_SHAMT       = 3'd4;

    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] ext_imm;
    logic              ext_err;

    logic              main_valid;
    logic [DATA_W-1:0] main_imm;
    logic [TAG_W-1:0]  main_tag;
    logic              main_err;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_err;

    logic              in_xfer;
    logic              out_xfer;

    assign sext_imm = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    // Extension happens at the input so the entry registers hold final operands.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (in_op)
            OP_ZERO:        ext_imm = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            OP_SIGNED:      ext_imm = sext_imm;
            OP_HIGHPOS:     ext_imm = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            OP_SIGNED_SHL2: ext_imm = {sext_imm[DATA_W-3:0], 2'b00};
            OP_SHAMT:       ext_imm = {{(DATA_W-SHAMT_W){1'b0}}, in_imm[SHAMT_W-1:0]};
            default: begin
                // Reserved opcodes yield a clean zero operand, never a stale one.
                ext_imm = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    // Skid occupancy alone gates acceptance, keeping in_ready a registered term.
    assign in_ready  = !skid_valid;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_imm   = main_imm;
    assign out_tag   = main_tag;
    assign out_err   = main_err;

    // Main/skid FIFO update; flush overrides every transfer in its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer) begin
            if (skid_valid) begin
                // in_ready is low here, so no new entry competes with the skid move.
                main_imm   <= skid_imm;
                main_tag   <= skid_tag;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_imm   <= ext_imm;
                main_tag   <= in_tag;
                main_err   <= ext_err;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_imm   <= ext_imm;
                main_tag   <= in_tag;
                main_err   <= ext_err;
            end else begin
                skid_valid <= 1'b1;
                skid_imm   <= ext_imm;
                skid_tag   <= in_tag;
                skid_err   <= ext_err;
            end
        end
    end

endmodule
